// File: rtl/key_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_evt_pkg
// Brief    : Shared event codes, per-key FSM state encoding and a clog2
//            helper for the key event controller.
// Revision : 1.0 - initial release
// ============================================================================
package key_evt_pkg;

    // Event type codes carried on evt_type
    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;
    localparam logic [1:0] EVT_REPEAT  = 2'd3;

    // Per-key sequencer states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HELD      = 2'd1,
        ST_LONG_HELD = 2'd2
    } key_state_t;

    // Ceiling log2, never less than 1 so that derived vectors stay legal
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_evt_fsm.sv
`default_nettype none
// ============================================================================
// Module   : key_evt_fsm
// Brief    : One key's input registers, press/hold sequencer, hold counter
//            and single-entry pending event slot.
//            Optional macro KEY_EVT_REPEAT_EN enables REPEAT events while the
//            key stays in the long-held state.
// Revision : 1.0 - initial release
// ============================================================================
module key_evt_fsm
    import key_evt_pkg::*;
#(
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int LONG_MS        = 1000,
    parameter int REPEAT_MS      = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_key_lvl,
    input  logic       i_tick,
    input  logic       i_grant,
    output logic       o_pend,
    output logic [1:0] o_type,
    output logic       o_ovf
);

    localparam int CNT_W = clog2((LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS);
    localparam logic [CNT_W-1:0] C_LONG_LAST = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
`ifdef KEY_EVT_REPEAT_EN
    localparam logic [CNT_W-1:0] C_REP_LAST  = CNT_W'(REPEAT_MS - 1);
`endif

    logic             r_p;
    logic             r_p_d;
    key_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;
    logic [1:0]       r_type;

    logic             w_rise;
    logic             w_fall;
    logic             w_post;
    logic [1:0]       w_post_type;

    assign w_rise = r_p & ~r_p_d;
    assign w_fall = ~r_p & r_p_d;

    // Decide whether this cycle posts an event; release wins over a tick
    always_comb begin
        w_post      = 1'b0;
        w_post_type = EVT_PRESS;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_post      = 1'b1;
                    w_post_type = EVT_PRESS;
                end
            end
            ST_HELD: begin
                if (w_fall) begin
                    w_post      = 1'b1;
                    w_post_type = EVT_RELEASE;
                end else if (i_tick && (r_cnt == C_LONG_LAST)) begin
                    w_post      = 1'b1;
                    w_post_type = EVT_LONG;
                end
            end
            ST_LONG_HELD: begin
                if (w_fall) begin
                    w_post      = 1'b1;
                    w_post_type = EVT_RELEASE;
                end
`ifdef KEY_EVT_REPEAT_EN
                else if (i_tick && (r_cnt == C_REP_LAST)) begin
                    w_post      = 1'b1;
                    w_post_type = EVT_REPEAT;
                end
`endif
            end
            default: begin
                w_post      = 1'b0;
                w_post_type = EVT_PRESS;
            end
        endcase
    end

    // Input sampling, sequencer, hold counter and pending slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p     <= 1'b0;
            r_p_d   <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_type  <= EVT_PRESS;
        end else begin
            r_p   <= (KEY_ACTIVE_LOW != 0) ? ~i_key_lvl : i_key_lvl;
            r_p_d <= r_p;

            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_cnt   <= '0;
                        r_state <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                    end else if (i_tick) begin
                        if (r_cnt == C_LONG_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_LONG_HELD;
                        end else if (r_cnt != C_CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_LONG_HELD: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                    end
`ifdef KEY_EVT_REPEAT_EN
                    else if (i_tick) begin
                        if (r_cnt == C_REP_LAST) begin
                            r_cnt <= '0;
                        end else if (r_cnt != C_CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // A same-cycle grant consumes the old type; the new post stays pending
            if (w_post) begin
                r_pend <= 1'b1;
                r_type <= w_post_type;
            end else if (i_grant) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_pend = r_pend;
    assign o_type = r_type;
    assign o_ovf  = w_post & r_pend & ~i_grant;

endmodule
`default_nettype wire

// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_event_ctrl
// Brief    : Turns debounced key levels into PRESS/RELEASE/LONG/REPEAT events
//            and merges them round-robin onto one valid/ready channel.
//            Optional macro KEY_EVT_REPEAT_EN enables auto-repeat events.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_ctrl
    import key_evt_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int TICK_DIV       = 50000,
    parameter int LONG_MS        = 1000,
    parameter int REPEAT_MS      = 200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_KEYS-1:0]       key_lvl,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [clog2(NUM_KEYS)-1:0] evt_key,
    output logic [1:0]                evt_type,
    output logic                      evt_ovf
);

    localparam int KEY_W = clog2(NUM_KEYS);
    localparam int PRE_W = clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [KEY_W-1:0] C_KEY_LAST = KEY_W'(NUM_KEYS - 1);

    logic [PRE_W-1:0]    r_presc;
    logic                w_tick;

    logic [NUM_KEYS-1:0] w_pend;
    logic [1:0]          w_type [NUM_KEYS];
    logic [NUM_KEYS-1:0] w_ovf;
    logic [NUM_KEYS-1:0] w_grant;

    logic                w_load;
    logic                w_found;
    logic [KEY_W-1:0]    w_gnt_idx;
    int                  w_scan;

    logic                r_valid;
    logic [KEY_W-1:0]    r_key;
    logic [1:0]          r_type;
    logic                r_ovf;
    logic [KEY_W-1:0]    r_rr;

    assign w_tick = (r_presc == C_PRE_LAST);

    // Shared millisecond time base
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
            key_evt_fsm #(
                .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
                .LONG_MS        (LONG_MS),
                .REPEAT_MS      (REPEAT_MS)
            ) u_fsm (
                .clk       (clk),
                .rst       (rst),
                .i_key_lvl (key_lvl[g]),
                .i_tick    (w_tick),
                .i_grant   (w_grant[g]),
                .o_pend    (w_pend[g]),
                .o_type    (w_type[g]),
                .o_ovf     (w_ovf[g])
            );
        end
    endgenerate

    // The output register may take a new event when empty or draining now
    assign w_load = ~r_valid | evt_ready;

    // Round-robin search for the first pending key at or after the pointer
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_grant   = '0;
        w_scan    = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_scan = int'(r_rr) + i;
            if (w_scan >= NUM_KEYS) begin
                w_scan = w_scan - NUM_KEYS;
            end
            if (!w_found && w_pend[w_scan]) begin
                w_found   = 1'b1;
                w_gnt_idx = KEY_W'(w_scan);
            end
        end
        if (w_load && w_found) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    // Output event register, pointer update and overflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_key   <= '0;
            r_type  <= EVT_PRESS;
            r_ovf   <= 1'b0;
            r_rr    <= '0;
        end else begin
            r_ovf <= |w_ovf;
            if (w_load) begin
                if (w_found) begin
                    r_valid <= 1'b1;
                    r_key   <= w_gnt_idx;
                    r_type  <= w_type[w_gnt_idx];
                    r_rr    <= (w_gnt_idx == C_KEY_LAST) ? '0 : w_gnt_idx + 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign evt_valid = r_valid;
    assign evt_key   = r_key;
    assign evt_type  = r_type;
    assign evt_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Sequences the debounced key levels of the keys_interface into timed key events: press, release, long-press and auto-repeat.
- Arbitrates the NUM_KEYS per-key event sources onto one valid/ready event channel, round-robin.
- Sits between the per-key debounce instances and the GUI menu/command logic.

Parameters:
- NUM_KEYS, 4, number of debounced key inputs (2..8).
- KEY_ACTIVE_LOW, 1, 1 = key_lvl bit low means pressed; 0 = high means pressed.
- TICK_DIV, 50000, clk cycles per 1 ms time-base tick (50 MHz clk).
- LONG_MS, 1000, hold time in ticks before the LONG event.
- REPEAT_MS, 200, period in ticks between REPEAT events after LONG.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- key_lvl  in  NUM_KEYS  debounced key levels, already synchronous to clk.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready at a clk edge.
- evt_key  out  clog2(NUM_KEYS)  index of the key that produced the event.
- evt_type  out  2  0=PRESS, 1=RELEASE, 2=LONG, 3=REPEAT.
- evt_ovf  out  1  one-cycle pulse when a pending event is overwritten before it is granted.

Behaviour:
- Reset: all outputs 0; all key FSMs IDLE; pend flags, tick prescaler, hold counters and RR pointer cleared to 0. Reset mid-handshake drops the held event.
- Sampling: key_lvl is registered once (p = pressed after polarity fix), then delayed once more for edge detection (p_d).
- Time base: prescaler counts 0..TICK_DIV-1; tick pulses for one cycle at wrap. The prescaler is shared by all keys.
- Per-key FSM, states IDLE, HELD, LONG_HELD:
  - IDLE, rising p: post PRESS, clear hold_cnt, go to HELD.
  - HELD, falling p: post RELEASE, go to IDLE.
  - HELD, on each tick: hold_cnt++. When hold_cnt reaches LONG_MS-1 on a tick: post LONG, clear hold_cnt, go to LONG_HELD.
  - LONG_HELD, on each tick: hold_cnt++. When hold_cnt reaches REPEAT_MS-1 on a tick: post REPEAT, clear hold_cnt.
  - LONG_HELD, falling p: post RELEASE, go to IDLE.
  - Release takes priority over a tick in the same cycle.
- hold_cnt width: clog2(max(LONG_MS,REPEAT_MS)). It saturates and never wraps.
- Pending slot, one per key (pend flag + 2-bit type):
  - A post sets pend and writes the type.
  - If pend is already set and not being granted in that cycle, the new type overwrites the old one and evt_ovf pulses.
  - If a post and a grant of the same key occur in the same cycle, the old type is granted and the new type stays pending; no ovf.
- Output register and arbiter:
  - When the output register is empty, or is being emptied this cycle (valid && ready), the arbiter grants the first pending key at or after the RR pointer, modulo NUM_KEYS.
  - The grant loads evt_key/evt_type, sets evt_valid, clears that key's pend, and moves the RR pointer to granted+1.
  - Back-to-back events are possible; throughput is one event per cycle.
  - evt_key and evt_type are stable while evt_valid=1 and evt_ready=0.
- Latency: a key_lvl edge in cycle N gives evt_valid=1 in cycle N+3, provided the output is free and no other key is pending.
- Simultaneous presses: each key posts its own PRESS; they are granted in RR order.

Optional Feature:
- Macro KEY_EVT_REPEAT_EN.
- Defined: LONG_HELD issues REPEAT events every REPEAT_MS ticks, as described above.
- Undefined: LONG_HELD only waits for release. No REPEAT is ever posted, and the REPEAT_MS counter logic is not built.

Decomposition:
- Package key_evt_pkg holds:
  - EVT_PRESS/EVT_RELEASE/EVT_LONG/EVT_REPEAT 2-bit constants;
  - the FSM state encoding ST_IDLE/ST_HELD/ST_LONG_HELD;
  - a clog2 helper function.
- One sub-module, key_evt_fsm, instantiated NUM_KEYS times in a generate loop. It contains the input registers, FSM, hold counter and pending slot, and exposes pend/type/grant.
- The prescaler, RR arbiter and output register live in the top module.

Test Plan (bench params TICK_DIV=10, LONG_MS=5, REPEAT_MS=2, NUM_KEYS=4, evt_ready=1 unless stated):
- Key1 pressed for 20 cycles, then released -> exactly PRESS(1) then RELEASE(1). PRESS valid 3 cycles after the edge; no LONG.
- Key2 held for 100 cycles -> PRESS, LONG about 50 cycles later, then REPEAT every 20 cycles (2 REPEATs), then RELEASE. With the macro undefined: PRESS, LONG, RELEASE only.
- Keys 0 and 3 pressed in the same cycle, RR pointer=1 -> PRESS(3) then PRESS(0) on consecutive cycles.
- evt_ready=0 while key0 press/release toggles twice -> single evt_ovf pulses; after ready=1, the last posted type is delivered and evt_key/evt_type were stable during the stall.
- rst asserted for 1 cycle while key2 is LONG_HELD with evt_valid=1 -> all outputs 0 next cycle. A still-held key produces a fresh PRESS after reset.
- KEY_ACTIVE_LOW=0 build, key0 driven high -> PRESS(0) with the same latency.
